// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding imem read at a time, then the word is held until the controller consumes it.
// Optional performance counters (fetch_count, stall_count) are compiled in with FETCH_PERF_EN.
module instruction_fetch #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     instruction,
  output logic [9:0]      opcode,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
`ifdef FETCH_PERF_EN
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count,
`endif
  output logic [PC_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target_aligned;
  logic            unused_target_bits;

  assign target_aligned     = {branch_target[PC_W-1:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];
  assign imem_addr          = pc;
  assign opcode             = instruction[31:22];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= {RESET_PC[PC_W-1:2], 2'b00};
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
    end else if (branch_taken) begin
      // A redirect wins everywhere; an already-issued read must still be drained in FLUSH.
      pc          <= target_aligned;
      instr_valid <= 1'b0;
      if ((state == FETCH || state == FLUSH) && !imem_valid) begin
        state    <= FLUSH;
        imem_req <= 1'b0;
      end else begin
        state    <= FETCH;
        imem_req <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            pc_out      <= pc;
            pc          <= pc + PC_W'(4);
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        FLUSH: begin
          if (imem_valid) begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_valid && instr_ready)
        fetch_count <= fetch_count + 32'd1;
      if ((state == FETCH || state == FLUSH) && !imem_valid)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic against a transaction-level model.
module tb_instruction_fetch;
  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic            clk = 1'b0;
  logic            rst, imem_req, imem_valid, instr_valid, instr_ready, branch_taken;
  logic [PC_W-1:0] imem_addr, branch_target, pc_out;
  logic [31:0]     imem_rdata, instruction;
  logic [9:0]      opcode;
`ifdef FETCH_PERF_EN
  logic [31:0]     fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instruction(instruction),
    .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .pc_out(pc_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: the unit is either warming up after reset, draining a cancelled read,
  // holding a word for the controller, or waiting on a read at m_pc.
  bit              m_idle, m_drop, m_iv;
  logic [PC_W-1:0] m_pc, m_pcout;
  logic [31:0]     m_instr;
  logic [31:0]     m_fc, m_sc;

  function automatic bit model_req();
    return !m_idle && !m_drop && !m_iv;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_req", 64'(imem_req), 64'(model_req()));
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 64'(instr_valid), 64'(m_iv));
    check("instruction", 64'(instruction), 64'(m_instr));
    check("opcode", 64'(opcode), 64'(m_instr >> 22));
    check("pc_out", pc_out, m_pcout);
`ifdef FETCH_PERF_EN
    check("fetch_count", 64'(fetch_count), 64'(m_fc));
    check("stall_count", 64'(stall_count), 64'(m_sc));
`endif
  endtask

  task automatic step(input bit r, input bit b, input logic [63:0] t,
                      input bit v, input logic [31:0] d, input bit y);
    bit req_prev, drop_prev, iv_prev;
    rst = r; branch_taken = b; branch_target = t;
    imem_valid = v; imem_rdata = d; instr_ready = y;
    req_prev = model_req(); drop_prev = m_drop; iv_prev = m_iv;
    @(posedge clk);
    if (r) begin
      m_idle = 1; m_drop = 0; m_iv = 0; m_instr = '0; m_pcout = '0;
      m_pc = {RESET_PC[PC_W-1:2], 2'b00}; m_fc = '0; m_sc = '0;
    end else begin
      if (iv_prev && y) m_fc++;
      if ((req_prev || drop_prev) && !v) m_sc++;
      if (b) begin
        m_pc = {t[63:2], 2'b00}; m_iv = 0; m_idle = 0;
        m_drop = (req_prev || drop_prev) && !v;
      end else if (m_idle) m_idle = 0;
      else if (m_drop) begin
        if (v) m_drop = 0;
      end else if (m_iv) begin
        if (y) m_iv = 0;
      end else if (v) begin
        m_instr = d; m_pcout = m_pc; m_pc = m_pc + 64'd4; m_iv = 1;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; branch_taken = 0; branch_target = '0; imem_valid = 0;
    imem_rdata = '0; instr_ready = 0;
    m_idle = 1; m_drop = 0; m_iv = 0; m_pc = '0; m_pcout = '0; m_instr = '0;
    m_fc = '0; m_sc = '0;

    // Reset and first fetch with the word returned two cycles after the request.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_req", 64'(imem_req), 64'd0);
    check("reset_instr", 64'(instruction), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    check("idle_to_fetch", 64'(imem_req), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hCB0380C6, 0);
    check("first_word", 64'(instruction), 64'hCB0380C6);
    check("first_opcode", 64'(opcode), 64'(10'b1100101100));
    check("first_pc_out", pc_out, 64'd0);

    // Controller stalls for five cycles, then consumes.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("hold_valid", 64'(instr_valid), 64'd1);
      check("hold_req", 64'(imem_req), 64'd0);
    end
    step(0, 0, 0, 0, 0, 1);
    check("next_req", 64'(imem_req), 64'd1);
    check("next_addr", imem_addr, 64'd4);

    // Branch one cycle into the fetch; the in-flight word must be dropped.
    step(0, 1, 64'h103, 0, 0, 0);
    check("flush_req", 64'(imem_req), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEADBEEF, 0);
    check("flush_drop_valid", 64'(instr_valid), 64'd0);
    check("flush_target", imem_addr, 64'h100);
    check("flush_refetch", 64'(imem_req), 64'd1);

    // Branch coincident with the returned word: straight to fetching the target.
    step(0, 1, 64'h202, 1, 32'h12345678, 0);
    check("same_cycle_valid", 64'(instr_valid), 64'd0);
    check("same_cycle_addr", imem_addr, 64'h200);
    check("same_cycle_req", 64'(imem_req), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    check("no_flush_req", 64'(imem_req), 64'd1);

    // Reset while holding a valid word.
    step(0, 0, 0, 1, 32'hA5A5A5A5, 0);
    check("pre_reset_valid", 64'(instr_valid), 64'd1);
    step(1, 1, 64'h300, 1, 32'h0, 1);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_pc_out", pc_out, 64'd0);
    check("rst_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", 64'(fetch_count), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
           {$urandom, $urandom}, $urandom_range(0, 99) < 40, $urandom,
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_W, default 64, SHALL set the program-counter and address width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset (bits [1:0] SHALL be treated as 00).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  output  PC_W  SHALL be the read address (current PC).
REQ-007 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-008 imem_valid  input  1  SHALL qualify imem_rdata for one cycle.
REQ-009 instruction  output  32  SHALL be the fetched word presented to the controller.
REQ-010 opcode  output  10  SHALL equal instruction[31:22] at all times.
REQ-011 instr_valid  output  1  SHALL flag instruction/opcode as valid.
REQ-012 instr_ready  input  1  SHALL indicate that the controller consumes the presented instruction this cycle.
REQ-013 branch_taken  input  1  SHALL request a redirect of the PC.
REQ-014 branch_target  input  PC_W  SHALL be the redirect address; bits [1:0] SHALL be ignored.
REQ-015 pc_out  output  PC_W  SHALL be the address of the presented instruction.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, HOLD and FLUSH, and SHALL be encoded in 2 bits.
REQ-017 IDLE SHALL drive imem_req=0 and SHALL move to FETCH unconditionally on the next cycle.
REQ-018 FETCH SHALL drive imem_req=1 with imem_addr=pc, held stable until imem_valid.
REQ-019 In FETCH with imem_valid=1 and no branch: instruction<=imem_rdata, pc_out<=pc, pc<=pc+4 (mod 2^PC_W), instr_valid<=1, next state HOLD.
REQ-020 HOLD SHALL keep instruction, opcode and pc_out stable with imem_req=0; on instr_ready=1: instr_valid<=0 and next state FETCH.
REQ-021 instr_ready while instr_valid=0 SHALL be ignored.
REQ-022 branch_taken SHALL have the highest priority in every state: pc<={branch_target[PC_W-1:2],2'b00} and instr_valid<=0.
REQ-023 On branch in FETCH without imem_valid in the same cycle, the next state SHALL be FLUSH; with imem_valid in the same cycle, the word SHALL be discarded and the next state SHALL be FETCH.
REQ-024 On branch in IDLE, HOLD or FLUSH, the next state SHALL be FETCH (for FLUSH only when imem_valid is seen in that cycle; otherwise the FSM SHALL stay in FLUSH with the new target).
REQ-025 FLUSH SHALL drive imem_req=0 and SHALL discard the next imem_valid word, then move to FETCH.
REQ-026 imem_valid outside FETCH or FLUSH SHALL be ignored.
REQ-027 The minimum latency SHALL be 1 cycle from imem_valid to instr_valid, and 1 cycle from instr_ready to the next imem_req.

Reset
REQ-028 rst=1 SHALL force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=0, opcode=0, pc_out=0, and perf counters=0.
REQ-029 rst SHALL override branch_taken and imem_valid in the same cycle, and a word returned after reset mid-FETCH SHALL be discarded (IDLE ignores imem_valid).

Configuration
REQ-030 With FETCH_PERF_EN defined, the block SHALL add the outputs fetch_count[31:0] (incremented on each accepted instr_ready handshake) and stall_count[31:0] (incremented on each FETCH/FLUSH cycle without imem_valid); both SHALL wrap at 2^32.
REQ-031 Without FETCH_PERF_EN, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then imem_valid two cycles after imem_req with rdata=0xCB0380C6, instr_ready=1 -> instruction=0xCB0380C6, opcode=10'b1100101100, pc_out=0, next imem_addr=4.
REQ-033 Hold instr_ready=0 for 5 cycles -> instr_valid stays 1, instruction stable, imem_req=0; on instr_ready=1 -> imem_addr=4 requested the next cycle.
REQ-034 branch_taken with target=0x103 one cycle after imem_req, imem_valid 2 cycles later -> returned word dropped, instr_valid never asserts for it, next imem_addr=0x100.
REQ-035 branch_taken in the same cycle as imem_valid -> word dropped, FETCH at the target on the next cycle, no FLUSH state.
REQ-036 rst asserted in HOLD with instr_valid=1 -> next cycle all outputs are 0 and imem_addr=RESET_PC; with FETCH_PERF_EN, fetch_count=0 and stall_count=0.
